// File: rtl/sonar_pkg.sv
// Constants and steering types shared by the sonar transmit and receive beamformers.
package sonar_pkg;

    localparam int SPEED_OF_SOUND  = 343000;  // mm/s
    localparam int ELEMENT_SPACING = 9;       // mm
    localparam int NUM_ELEMENTS    = 4;
    localparam int SIN_WIDTH       = 17;
    localparam int SIN_ONE         = 1 << (SIN_WIDTH - 1);

    typedef struct packed {
        logic [SIN_WIDTH-1:0] sin_theta;
        logic                 sign_bit;
    } steer_t;

    typedef enum logic {
        FILL = 1'b0,
        RUN  = 1'b1
    } bf_state_e;

    // Element delay multiplier: steering left mirrors the array so the rightmost element waits longest.
    function automatic int unsigned elem_k(input int unsigned idx, input logic sign_bit,
                                           input int unsigned n);
        return sign_bit ? (n - 1 - idx) : idx;
    endfunction

endpackage

// File: rtl/receive_beamformer_if.sv
// Steering, sample and beam signals between the receive beamformer and its neighbours.
interface receive_beamformer_if #(
    parameter int NUM_RECEIVERS = 4,
    parameter int SAMPLE_WIDTH  = 16,
    parameter int SIN_WIDTH     = 17
);
    localparam int BEAM_W = SAMPLE_WIDTH + $clog2(NUM_RECEIVERS);

    logic [SIN_WIDTH-1:0]                  sin_theta;
    logic                                  sign_bit;
    logic                                  angle_load;
    logic                                  sample_valid;
    logic [NUM_RECEIVERS*SAMPLE_WIDTH-1:0] samples_in;
    logic signed [BEAM_W-1:0]              beam_out;
    logic                                  beam_valid;
    logic                                  filling;

    modport master (
        output sin_theta, sign_bit, angle_load, sample_valid, samples_in,
        input  beam_out, beam_valid, filling
    );

    modport slave (
        input  sin_theta, sign_bit, angle_load, sample_valid, samples_in,
        output beam_out, beam_valid, filling
    );
endinterface

// File: rtl/sample_delay_line.sv
// Single-channel circular delay line: writes on strobe, returns the sample `delay_i` strobes old.
module sample_delay_line #(
    parameter  int WIDTH = 16,
    parameter  int DEPTH = 128,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             we_i,
    input  logic [AW-1:0]    wr_ptr_i,
    input  logic [AW-1:0]    delay_i,
    input  logic [WIDTH-1:0] din_i,
    output logic [WIDTH-1:0] dout_o
);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] rd_q;
    logic [AW-1:0]    rd_addr;

    // Modulo-DEPTH wrap comes for free from the AW-bit subtraction.
    assign rd_addr = wr_ptr_i - delay_i;

    always_ff @(posedge clk_in) begin
        if (we_i) mem[wr_ptr_i] <= din_i;
    end

    // Zero delay has to bypass: the current sample is not in memory yet.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in)   rd_q <= '0;
        else if (we_i) rd_q <= (delay_i == '0) ? din_i : mem[rd_addr];
    end

    assign dout_o = rd_q;
endmodule

// File: rtl/receive_beamformer.sv
// Delay-and-sum receive beamformer: per-channel steering delays, fill tracking and a 2-stage sum.
module receive_beamformer
    import sonar_pkg::*;
#(
    parameter int NUM_RECEIVERS   = NUM_ELEMENTS,
    parameter int ELEM_SPACING    = ELEMENT_SPACING,
    parameter int SOUND_SPEED     = SPEED_OF_SOUND,
    parameter int SAMPLE_RATE     = 1000000,
    parameter int SAMPLE_WIDTH    = 16,
    parameter int SIN_W           = SIN_WIDTH,
    parameter int BUF_DEPTH       = 128
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    receive_beamformer_if.slave  bus
);
    localparam int AW        = $clog2(BUF_DEPTH);
    localparam int BEAM_W    = SAMPLE_WIDTH + $clog2(NUM_RECEIVERS);
    localparam int MAX_DELAY = BUF_DEPTH - 1;
    localparam int DPR       = ELEM_SPACING * SAMPLE_RATE / SOUND_SPEED;
    localparam int STAGES    = 2;

    function automatic logic [AW-1:0] calc_delay(input int unsigned k, input logic [SIN_W-1:0] s);
        logic [63:0] prod;
        prod = (64'(DPR) * 64'(k) * 64'(s)) >> (SIN_W - 1);
        if (prod > 64'(MAX_DELAY)) return AW'(MAX_DELAY);
        return prod[AW-1:0];
    endfunction

    steer_t steer;
    assign steer = '{sin_theta: bus.sin_theta, sign_bit: bus.sign_bit};

    // Steering delays
    logic [NUM_RECEIVERS-1:0][AW-1:0] dly_q, dly_d;

    always_comb begin
        dly_d = dly_q;
        if (bus.angle_load) begin
            for (int unsigned i = 0; i < NUM_RECEIVERS; i++)
                dly_d[i] = calc_delay(elem_k(i, steer.sign_bit, NUM_RECEIVERS), steer.sin_theta);
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) dly_q <= '0;
        else         dly_q <= dly_d;
    end

    // Shared write pointer
    logic [AW-1:0] wr_ptr_q;

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in)               wr_ptr_q <= '0;
        else if (bus.sample_valid) wr_ptr_q <= wr_ptr_q + 1'b1;
    end

    // Fill/run control
    bf_state_e     state_q;
    logic [AW-1:0] fill_cnt_q;
    logic          filling_q;

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q    <= FILL;
            fill_cnt_q <= '0;
            filling_q  <= 1'b1;
        end else begin
            case (state_q)
                FILL: if (bus.sample_valid) begin
                    fill_cnt_q <= fill_cnt_q + 1'b1;
                    if (fill_cnt_q == AW'(MAX_DELAY - 1)) begin
                        state_q   <= RUN;
                        filling_q <= 1'b0;
                    end
                end
                RUN:     state_q <= RUN;
                default: state_q <= FILL;
            endcase
        end
    end

    // Stage 1: one delay line per receiver
    logic [NUM_RECEIVERS-1:0][SAMPLE_WIDTH-1:0] dsmp;

    for (genvar g = 0; g < NUM_RECEIVERS; g++) begin : g_ch
        sample_delay_line #(
            .WIDTH (SAMPLE_WIDTH),
            .DEPTH (BUF_DEPTH)
        ) u_dl (
            .clk_in   (clk_in),
            .rst_in   (rst_in),
            .we_i     (bus.sample_valid),
            .wr_ptr_i (wr_ptr_q),
            .delay_i  (dly_q[g]),
            .din_i    (bus.samples_in[g*SAMPLE_WIDTH +: SAMPLE_WIDTH]),
            .dout_o   (dsmp[g])
        );
    end

    // Stage 2: sign-extended sum, wide enough that it cannot overflow
    logic signed [BEAM_W-1:0] sum_d, beam_q;

    always_comb begin
        sum_d = '0;
        for (int i = 0; i < NUM_RECEIVERS; i++)
            sum_d = sum_d + BEAM_W'($signed(dsmp[i]));
    end

    logic              vld_in;
    logic [STAGES:1]   vld_q;

    // Samples accepted while priming never reach the output.
    assign vld_in = bus.sample_valid && (state_q == RUN);

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            vld_q  <= '0;
            beam_q <= '0;
        end else begin
            vld_q <= {vld_q[STAGES-1:1], vld_in};
            if (vld_q[1]) beam_q <= sum_d;
        end
    end

    assign bus.beam_out   = beam_q;
    assign bus.beam_valid = vld_q[STAGES];
    assign bus.filling    = filling_q;
endmodule

// File: tb/tb_receive_beamformer.sv
// Bench for receive_beamformer: directed tables, impulse sequences and a random run against a sample-history model.
module tb_receive_beamformer;
    localparam int N    = 4;
    localparam int W    = 16;
    localparam int SW   = 17;
    localparam int MAXD = 127;
    localparam int DPR  = 9 * 1000000 / 343000;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    receive_beamformer_if bus();
    receive_beamformer dut (.clk_in(clk), .rst_in(rst_n), .bus(bus));

    typedef struct { int due; int val; } exp_t;
    typedef struct { int v; int exp; } const_vec_t;
    typedef struct { int s; bit sb; int ch; int amp; int lat; } imp_vec_t;

    exp_t expq[$];
    int   hist[N][$];
    int   dcur[N];
    int   n_ep, cycle, gsn, first_src;
    int   cyc_gsn[int];
    int   out_val[int];
    int   checks, failures;

    const_vec_t cvec[5];
    imp_vec_t   ivec[7];

    // Delay from the geometry: elements further from the steering side wait k*DPR*sin samples.
    function automatic int model_delay(input int k, input int s);
        longint p;
        p = (longint'(DPR) * k * s) / 65536;
        return (p > MAXD) ? MAXD : int'(p);
    endfunction

    function automatic logic [N*W-1:0] all_ch(input int v);
        logic [N*W-1:0] r;
        for (int i = 0; i < N; i++) r[i*W +: W] = W'(v);
        return r;
    endfunction

    function automatic logic [N*W-1:0] one_ch(input int ch, input int v);
        logic [N*W-1:0] r;
        r = '0;
        r[ch*W +: W] = W'(v);
        return r;
    endfunction

    function automatic int got_at(input int k);
        return out_val.exists(k) ? out_val[k] : -999999;
    endfunction

    task automatic chk(input string name, input int got, input int want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s cyc=%0d got=%0d want=%0d", name, cycle, got, want);
        end
    endtask

    task automatic check_outputs();
        bit ev;
        int src;
        ev = (expq.size() > 0) && (expq[0].due == cycle);
        chk("beam_valid", int'(bus.beam_valid), int'(ev));
        if (bus.beam_valid === 1'b1) begin
            src = cyc_gsn.exists(cycle - 2) ? cyc_gsn[cycle - 2] : -1;
            out_val[src] = int'(bus.beam_out);
            if (first_src < 0) first_src = src;
        end
        if (ev) begin
            chk("beam_out", int'(bus.beam_out), expq[0].val);
            void'(expq.pop_front());
        end
        chk("filling", int'(bus.filling), int'(n_ep < MAXD));
    endtask

    task automatic cyc(input bit sv, input logic [N*W-1:0] smp, input bit al, input int s, input bit sb);
        int sum;
        bus.sample_valid = sv;
        bus.samples_in   = smp;
        bus.angle_load   = al;
        bus.sin_theta    = SW'(s);
        bus.sign_bit     = sb;
        if (sv) begin
            for (int i = 0; i < N; i++) hist[i].push_back(int'($signed(smp[i*W +: W])));
            if (n_ep >= MAXD) begin
                sum = 0;
                for (int i = 0; i < N; i++) sum += hist[i][n_ep - dcur[i]];
                expq.push_back('{due: cycle + 2, val: sum});
            end
            cyc_gsn[cycle] = gsn;
            gsn++;
            n_ep++;
        end
        if (al) for (int i = 0; i < N; i++) dcur[i] = model_delay(sb ? (N - 1 - i) : i, s);
        @(posedge clk);
        #1;
        cycle++;
        check_outputs();
        bus.sample_valid = 1'b0;
        bus.angle_load   = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) cyc(1'b0, '0, 1'b0, 0, 1'b0);
    endtask

    task automatic load(input int s, input bit sb);
        cyc(1'b0, '0, 1'b1, s, sb);
    endtask

    // Reset asserted between edges; outputs must drop without waiting for a clock.
    task automatic reset_now();
        bus.sample_valid = 1'b0;
        bus.angle_load   = 1'b0;
        rst_n = 1'b0;
        #1;
        expq.delete();
        for (int i = 0; i < N; i++) begin
            hist[i].delete();
            dcur[i] = 0;
        end
        n_ep = 0;
        first_src = -1;
        chk("rst_beam_valid", int'(bus.beam_valid), 0);
        chk("rst_filling", int'(bus.filling), 1);
        chk("rst_beam_out", int'(bus.beam_out), 0);
        repeat (2) begin
            @(posedge clk);
            #1;
            cycle++;
            chk("rst_hold_valid", int'(bus.beam_valid), 0);
        end
        rst_n = 1'b1;
    endtask

    initial begin
        int st, imp, nz;
        logic [N*W-1:0] v;
        checks = 0; failures = 0; cycle = 0; gsn = 0; n_ep = 0; first_src = -1;
        bus.sample_valid = 1'b0; bus.angle_load = 1'b0; bus.samples_in = '0;
        bus.sin_theta = '0; bus.sign_bit = 1'b0;

        cvec[0] = '{1000, 4000};
        cvec[1] = '{-32768, -131072};
        cvec[2] = '{32767, 131068};
        cvec[3] = '{-1, -4};
        cvec[4] = '{0, 0};

        ivec[0] = '{65536, 1'b0, 3, 500, 78};
        ivec[1] = '{32768, 1'b1, 0, 500, 39};
        ivec[2] = '{32768, 1'b1, 3, -500, 0};
        ivec[3] = '{131071, 1'b0, 3, -700, 127};
        ivec[4] = '{65536, 1'b1, 0, 300, 78};
        ivec[5] = '{98304, 1'b0, 1, 1234, 39};
        ivec[6] = '{0, 1'b1, 2, 77, 0};

        @(posedge clk);
        #1;
        reset_now();

        // Priming: first beam on strobe 127, constant sum thereafter
        st = gsn;
        repeat (200) cyc(1'b1, all_ch(1000), 1'b0, 0, 1'b0);
        idle(2);
        chk("first_valid_strobe", first_src - st, 127);
        chk("const_1000_last", got_at(st + 199), 4000);

        foreach (cvec[t]) begin
            load(0, 1'b0);
            repeat (4) cyc(1'b1, all_ch(cvec[t].v), 1'b0, 0, 1'b0);
            idle(2);
            chk("const_table", got_at(gsn - 1), cvec[t].exp);
        end

        foreach (ivec[t]) begin
            load(ivec[t].s, ivec[t].sb);
            repeat (130) cyc(1'b1, '0, 1'b0, 0, 1'b0);
            imp = gsn;
            cyc(1'b1, one_ch(ivec[t].ch, ivec[t].amp), 1'b0, 0, 1'b0);
            repeat (130) cyc(1'b1, '0, 1'b0, 0, 1'b0);
            idle(2);
            nz = 0;
            for (int j = 0; j <= 130; j++) if (got_at(imp + j) != 0) nz++;
            chk("impulse_count", nz, 1);
            chk("impulse_at_lat", got_at(imp + ivec[t].lat), ivec[t].amp);
        end

        // Angle load coincident with a strobe: that strobe still sees the old (zero) delays
        load(0, 1'b0);
        repeat (130) cyc(1'b1, '0, 1'b0, 0, 1'b0);
        for (int i = 0; i < N; i++) v[i*W +: W] = W'(100 * (i + 1));
        st = gsn;
        cyc(1'b1, v, 1'b1, 65536, 1'b0);
        repeat (100) cyc(1'b1, '0, 1'b0, 0, 1'b0);
        idle(2);
        chk("coincident_old", got_at(st), 1000);
        chk("coincident_new1", got_at(st + 26), 200);
        chk("coincident_new2", got_at(st + 52), 300);
        chk("coincident_new3", got_at(st + 78), 400);

        // Random steering and data
        repeat (800) begin
            for (int i = 0; i < N; i++) v[i*W +: W] = W'($urandom);
            cyc($urandom_range(0, 9) < 7, v, $urandom_range(0, 29) == 0,
                int'($urandom_range(0, 131071)), 1'($urandom_range(0, 1)));
        end

        // Back-to-back strobes with reset in the middle
        repeat (150) begin
            for (int i = 0; i < N; i++) v[i*W +: W] = W'($urandom);
            cyc(1'b1, v, 1'b0, 0, 1'b0);
        end
        reset_now();
        st = gsn;
        repeat (150) begin
            for (int i = 0; i < N; i++) v[i*W +: W] = W'($urandom);
            cyc(1'b1, v, 1'b0, 0, 1'b0);
        end
        idle(2);
        chk("post_reset_first_valid", first_src - st, 127);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
